// File: rtl/if_fetch.sv
// Instruction fetch: one AXI read per fetch, result registered to decode; 3-cycle minimum IDLE->IDLE.
// hold_if freezes the request side and outputs; an outstanding read always completes, flush only drops its data.
module if_fetch #(
    parameter int          ADDR_W    = 64,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pc_addr,
    input  logic              hold_if,
    input  logic              flush,
    output logic              axi_idle_if,
    output logic              ar_valid,
    input  logic              ar_ready,
    output logic [ADDR_W-1:0] ar_addr,
    input  logic              r_valid,
    output logic              r_ready,
    input  logic [31:0]       r_data,
    input  logic [1:0]        r_resp,
    output logic [31:0]       instr_id,
    output logic [ADDR_W-1:0] pc_id,
    output logic              valid_id,
    output logic [1:0]        err_id
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_ar_addr;
    logic [31:0]       r_instr;
    logic [ADDR_W-1:0] r_pc;
    logic              r_valid_id;
    logic [1:0]        r_err;
    logic              w_issue;
    logic              w_misalign;
    logic              w_hs;

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_misalign  = 1'b0;
        w_hs        = 1'b0;
        case (r_state)
            IDLE: begin
                if (!hold_if) begin
                    if (pc_addr[1:0] == 2'b00) begin
                        w_issue     = 1'b1;
                        w_state_nxt = ADDR;
                    end else begin
                        w_misalign = 1'b1;
                    end
                end
            end
            ADDR: begin
                if (ar_ready) begin
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                if (r_valid && !hold_if) begin
                    w_hs        = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_ar_addr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_issue) begin
                r_ar_addr <= pc_addr;
            end
        end
    end

    // Handshake / misalign take priority over a plain flush; flush beats hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr    <= NOP_INSTR;
            r_pc       <= '0;
            r_valid_id <= 1'b0;
            r_err      <= 2'b00;
        end else if (w_hs) begin
            r_pc       <= r_ar_addr;
            r_valid_id <= !flush;
            if (r_resp == 2'b00) begin
                r_instr <= flush ? NOP_INSTR : r_data;
                r_err   <= 2'b00;
            end else begin
                r_instr <= NOP_INSTR;
                r_err   <= 2'b01;
            end
        end else if (w_misalign) begin
            r_instr    <= NOP_INSTR;
            r_pc       <= pc_addr;
            r_valid_id <= !flush;
            r_err      <= 2'b10;
        end else if (flush) begin
            r_instr    <= NOP_INSTR;
            r_valid_id <= 1'b0;
            r_err      <= 2'b00;
        end
    end

    // Gated by rst_n so a misaligned PC cannot strobe the PC stage during reset.
    assign axi_idle_if = rst_n && (w_hs || w_misalign);
    assign ar_valid    = (r_state == ADDR);
    assign r_ready     = (r_state == DATA) && !hold_if;
    assign ar_addr     = r_ar_addr;
    assign instr_id    = r_instr;
    assign pc_id       = r_pc;
    assign valid_id    = r_valid_id;
    assign err_id      = r_err;

endmodule

// File: tb/tb_if_fetch.sv
module tb_if_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic [63:0] pc_addr;
    logic        hold_if;
    logic        flush;
    logic        axi_idle_if;
    logic        ar_valid;
    logic        ar_ready;
    logic [63:0] ar_addr;
    logic        r_valid;
    logic        r_ready;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
    logic [31:0] instr_id;
    logic [63:0] pc_id;
    logic        valid_id;
    logic [1:0]  err_id;

    if_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc_addr     (pc_addr),
        .hold_if     (hold_if),
        .flush       (flush),
        .axi_idle_if (axi_idle_if),
        .ar_valid    (ar_valid),
        .ar_ready    (ar_ready),
        .ar_addr     (ar_addr),
        .r_valid     (r_valid),
        .r_ready     (r_ready),
        .r_data      (r_data),
        .r_resp      (r_resp),
        .instr_id    (instr_id),
        .pc_id       (pc_id),
        .valid_id    (valid_id),
        .err_id      (err_id)
    );

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        logic        v;
        logic [1:0]  err;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          npulse = 0;
    int          nfetch = 0;
    logic [31:0] last_instr = NOP;
    logic [63:0] last_pc    = '0;
    logic        last_v     = 1'b0;
    logic [1:0]  last_err   = 2'b00;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] instr, input logic [63:0] pc,
                            input logic v, input logic [1:0] err);
        exp_t e;
        e.instr = instr;
        e.pc    = pc;
        e.v     = v;
        e.err   = err;
        exp_q.push_back(e);
        nfetch++;
    endtask

    // Scoreboard: a strobe seen before an edge means the outputs after that edge must match.
    always begin
        logic hs;
        exp_t e;
        @(negedge clk);
        #3;
        hs = axi_idle_if;
        @(posedge clk);
        #2;
        if (hs) begin
            npulse++;
            if (exp_q.size() == 0) begin
                chk("sb_nonempty", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                chk("sb_instr", 64'(instr_id), 64'(e.instr));
                chk("sb_pc",    pc_id,          e.pc);
                chk("sb_valid", 64'(valid_id),  64'(e.v));
                chk("sb_err",   64'(err_id),    64'(e.err));
                last_instr = e.instr;
                last_pc    = e.pc;
                last_v     = e.v;
                last_err   = e.err;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    // Full aligned fetch. fl holds flush from ADDR entry through the handshake.
    task automatic fetch(input logic [63:0] pc, input int ar_dly, input int r_dly,
                         input logic [31:0] d, input logic [1:0] rs, input logic fl,
                         input logic hold_data);
        int c0;
        int exp_period;
        push_exp((fl || rs != 2'b00) ? NOP : d, pc, !fl, (rs == 2'b00) ? 2'b00 : 2'b01);
        exp_period = 3 + ar_dly + r_dly + (hold_data ? 2 : 0);
        @(negedge clk);
        c0 = cyc;
        pc_addr  = pc;
        hold_if  = 1'b0;
        ar_ready = 1'b0;
        @(negedge clk);
        flush = fl;
        for (int i = 0; i < ar_dly; i++) begin
            #1;
            chk("addr_ar_valid", 64'(ar_valid), 64'd1);
            chk("addr_stable",   ar_addr,       pc);
            chk("addr_no_idle",  64'(axi_idle_if), 64'd0);
            hold_if = ~hold_if;
            @(negedge clk);
        end
        ar_ready = 1'b1;
        #1;
        chk("ar_valid", 64'(ar_valid), 64'd1);
        chk("ar_addr",  ar_addr,       pc);
        @(negedge clk);
        ar_ready = 1'b0;
        if (hold_data) begin
            for (int i = 0; i < 2; i++) begin
                r_valid = 1'b1;
                r_data  = d;
                r_resp  = rs;
                hold_if = 1'b1;
                #1;
                chk("hold_r_ready", 64'(r_ready),     64'd0);
                chk("hold_no_idle", 64'(axi_idle_if), 64'd0);
                chk("hold_instr",   64'(instr_id),    64'(last_instr));
                chk("hold_pc",      pc_id,            last_pc);
                chk("hold_valid",   64'(valid_id),    64'(last_v));
                chk("hold_err",     64'(err_id),      64'(last_err));
                @(negedge clk);
            end
        end
        for (int i = 0; i < r_dly; i++) begin
            r_valid = 1'b0;
            hold_if = 1'b0;
            #1;
            chk("data_r_ready", 64'(r_ready),     64'd1);
            chk("data_no_idle", 64'(axi_idle_if), 64'd0);
            @(negedge clk);
        end
        r_valid = 1'b1;
        r_data  = d;
        r_resp  = rs;
        hold_if = 1'b0;
        #1;
        chk("hs_r_ready", 64'(r_ready),     64'd1);
        chk("hs_idle",    64'(axi_idle_if), 64'd1);
        @(negedge clk);
        r_valid = 1'b0;
        flush   = 1'b0;
        hold_if = 1'b1;
        #1;
        chk("period",        64'(cyc - c0), 64'(exp_period));
        chk("back_idle_arv", 64'(ar_valid), 64'd0);
    endtask

    task automatic misaligned(input logic [63:0] pc, input logic fl);
        push_exp(NOP, pc, !fl, 2'b10);
        @(negedge clk);
        pc_addr = pc;
        hold_if = 1'b0;
        flush   = fl;
        #1;
        chk("mis_idle",     64'(axi_idle_if), 64'd1);
        chk("mis_ar_valid", 64'(ar_valid),    64'd0);
        @(negedge clk);
        hold_if = 1'b1;
        flush   = 1'b0;
        #1;
        chk("mis_no_req",   64'(ar_valid),    64'd0);
        chk("mis_one_idle", 64'(axi_idle_if), 64'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        pc_addr  = 64'h8000_0000;
        hold_if  = 1'b1;
        flush    = 1'b0;
        ar_ready = 1'b0;
        r_valid  = 1'b0;
        r_data   = '0;
        r_resp   = 2'b00;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ar_valid", 64'(ar_valid),    64'd0);
        chk("rst_r_ready",  64'(r_ready),     64'd0);
        chk("rst_idle",     64'(axi_idle_if), 64'd0);
        chk("rst_ar_addr",  ar_addr,          64'd0);
        chk("rst_instr",    64'(instr_id),    64'(NOP));
        chk("rst_pc",       pc_id,            64'd0);
        chk("rst_valid",    64'(valid_id),    64'd0);
        chk("rst_err",      64'(err_id),      64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("idle_hold_arv",  64'(ar_valid),    64'd0);
            chk("idle_hold_idle", 64'(axi_idle_if), 64'd0);
        end

        fetch(64'h8000_0000, 0, 0, 32'h0010_0093, 2'b00, 1'b0, 1'b0);
        fetch(64'h8000_0004, 4, 0, 32'h0020_0113, 2'b00, 1'b0, 1'b0);
        fetch(64'h8000_0008, 0, 1, 32'h0030_0193, 2'b00, 1'b0, 1'b1);
        fetch(64'h8000_000C, 2, 0, 32'h0040_0213, 2'b00, 1'b1, 1'b0);
        fetch(64'h8000_0040, 0, 2, 32'h0050_0293, 2'b00, 1'b0, 1'b0);
        fetch(64'h8000_0010, 1, 1, 32'hDEAD_BEEF, 2'b10, 1'b0, 1'b0);

        // Flush while stalled in IDLE clears the decode slot but keeps pc_id.
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("iflush_valid", 64'(valid_id),    64'd0);
        chk("iflush_instr", 64'(instr_id),    64'(NOP));
        chk("iflush_err",   64'(err_id),      64'd0);
        chk("iflush_pc",    pc_id,            64'h8000_0010);
        chk("iflush_idle",  64'(axi_idle_if), 64'd0);

        misaligned(64'h8000_0002, 1'b0);
        misaligned(64'h8000_0103, 1'b1);

        // Reset while ADDR is outstanding, then a stale r_valid.
        @(negedge clk);
        pc_addr = 64'h8000_0100;
        hold_if = 1'b0;
        @(negedge clk);
        hold_if = 1'b1;
        #1;
        chk("pre_rst_arv", 64'(ar_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_ar_valid", 64'(ar_valid),    64'd0);
        chk("arst_r_ready",  64'(r_ready),     64'd0);
        chk("arst_idle",     64'(axi_idle_if), 64'd0);
        chk("arst_ar_addr",  ar_addr,          64'd0);
        chk("arst_instr",    64'(instr_id),    64'(NOP));
        chk("arst_pc",       pc_id,            64'd0);
        chk("arst_valid",    64'(valid_id),    64'd0);
        chk("arst_err",      64'(err_id),      64'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        r_valid = 1'b1;
        r_data  = 32'h1234_5678;
        #1;
        chk("late_r_ready", 64'(r_ready),     64'd0);
        chk("late_idle",    64'(axi_idle_if), 64'd0);
        @(negedge clk);
        #1;
        chk("late_valid",   64'(valid_id), 64'd0);
        chk("late_instr",   64'(instr_id), 64'(NOP));
        r_valid = 1'b0;

        repeat (3) @(negedge clk);
        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        chk("pulses",     64'(npulse),       64'(nfetch));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter ADDR_W, default 64: width of PC and AXI read address.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013: instruction word driven when no valid instruction is present.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 pc_addr  input  ADDR_W  current fetch address from the PC stage.
REQ-006 hold_if  input  1  stall request for the fetch stage from the pipeline hold controller.
REQ-007 flush  input  1  jump taken; held by the source until the fetch stage reports completion.
REQ-008 axi_idle_if  output  1  fetch-complete strobe; permits the PC stage to advance.
REQ-009 ar_valid  output  1  AXI read-address valid.
REQ-010 ar_ready  input  1  AXI read-address ready.
REQ-011 ar_addr  output  ADDR_W  AXI read address.
REQ-012 r_valid  input  1  AXI read-data valid.
REQ-013 r_ready  output  1  AXI read-data ready.
REQ-014 r_data  input  32  AXI read data (one instruction).
REQ-015 r_resp  input  2  AXI read response; 2'b00 = OKAY.
REQ-016 instr_id  output  32  instruction to the decode stage.
REQ-017 pc_id  output  ADDR_W  address of instr_id.
REQ-018 valid_id  output  1  instr_id/pc_id carry a real instruction.
REQ-019 err_id  output  2  fetch error: 00 none, 01 bus error, 10 misaligned PC.

Function
REQ-020 The FSM SHALL have three states: IDLE, ADDR, DATA.
REQ-021 In IDLE with hold_if=0 and pc_addr[1:0]==0, the FSM SHALL latch pc_addr into ar_addr and go to ADDR.
REQ-022 In IDLE with hold_if=0 and pc_addr[1:0]!=0, the block SHALL issue no AXI request, pulse axi_idle_if for one cycle, and at that edge load instr_id=NOP_INSTR, pc_id=pc_addr, err_id=10, valid_id=!flush.
REQ-023 In IDLE with hold_if=1, the FSM SHALL stay in IDLE and axi_idle_if SHALL be 0.
REQ-024 ar_valid SHALL be 1 exactly while in ADDR; ar_addr SHALL be stable while ar_valid=1.
REQ-025 ADDR SHALL go to DATA on ar_valid&ar_ready; otherwise stay in ADDR regardless of hold_if and flush.
REQ-026 r_ready SHALL equal (state==DATA)&&!hold_if.
REQ-027 The handshake cycle is state==DATA && r_valid && r_ready; axi_idle_if SHALL be 1 in that cycle and 0 in all other cycles except REQ-022.
REQ-028 On the handshake edge the FSM SHALL return to IDLE, and outputs SHALL load pc_id=ar_addr, valid_id=!flush, and one of: instr_id=r_data with err_id=00 when r_resp==00; instr_id=NOP_INSTR with err_id=01 otherwise.
REQ-029 Minimum fetch latency: 3 cycles from IDLE to next IDLE (IDLE, ADDR with ar_ready=1, DATA with r_valid=1).
REQ-030 With hold_if=1 and no flush, instr_id, pc_id, valid_id and err_id SHALL hold their values.
REQ-031 flush=1 outside a handshake/misalign cycle SHALL clear valid_id to 0, instr_id to NOP_INSTR and err_id to 00 at the next edge, including while hold_if=1; it SHALL NOT abort an outstanding AXI transaction.
REQ-032 An outstanding transaction SHALL always be completed on AXI; its data SHALL be discarded (valid_id=0) when flush=1 in the handshake cycle.
REQ-033 Exactly one axi_idle_if pulse SHALL be produced per fetch, so the PC advances once per fetched word.

Reset
REQ-034 Reset SHALL asynchronously force state=IDLE, ar_valid=0, r_ready=0, ar_addr=0, axi_idle_if=0, instr_id=NOP_INSTR, pc_id=0, valid_id=0, err_id=00.
REQ-035 Reset asserted mid-transaction SHALL drop ar_valid and r_ready immediately; a late r_valid after reset release SHALL be ignored while in IDLE/ADDR.

Verification
REQ-036 pc_addr=0x8000_0000, ar_ready=1, r_valid=1 next cycle, r_data=0x0010_0093, r_resp=00 -> ar_addr=0x8000_0000, one axi_idle_if pulse, instr_id=0x0010_0093, pc_id=0x8000_0000, valid_id=1, 3-cycle period.
REQ-037 ar_ready held 0 for 4 cycles, hold_if toggling -> ar_valid stays 1, ar_addr stable, no axi_idle_if pulse until the handshake.
REQ-038 hold_if=1 while in DATA with r_valid=1 -> r_ready=0, outputs frozen; release -> handshake in the same cycle, axi_idle_if=1.
REQ-039 flush=1 during DATA handshake -> valid_id=0, instr_id=0x0000_0013, one axi_idle_if pulse, next ar_addr=new pc_addr.
REQ-040 r_resp=2'b10 -> instr_id=0x0000_0013, err_id=01, valid_id=1; pc_addr=0x8000_0002 -> no ar_valid, err_id=10, axi_idle_if pulse.
REQ-041 rst_n=0 while in ADDR -> ar_valid=0 asynchronously, all outputs at REQ-034 values.
